// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter: registered one-hot grant, zero-bubble handoff.
// Optional hold-time preemption is compiled in when RR_ARB_TIMEOUT_EN is defined.
module rr_arbiter_4 #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       gnt_valid,
    output logic       preempt
);
    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state, state_nxt;
    logic [1:0] last_idx, last_nxt, idx_nxt;
    logic [3:0] gnt_nxt;
    logic       new_grant;
    logic       timeout;
    logic [2:0] pick_any, pick_other;

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("rr_arbiter_4: TIMEOUT_CYCLES must be within 2..255");
    end

    // Returns {found, index}: first set bit of mask searching from last+1, wrapping.
    function automatic logic [2:0] rr_pick(input logic [3:0] mask, input logic [1:0] last);
        logic [2:0] result;
        logic [1:0] cand;
        result = 3'b000;
        // Walk from lowest to highest priority so the last hit is the winner.
        for (int k = 4; k >= 1; k--) begin
            cand = last + 2'(k);
            if (mask[cand]) result = {1'b1, cand};
        end
        return result;
    endfunction

    assign gnt_valid = (state == GRANT);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_nxt  = state;
        idx_nxt    = gnt_idx;
        last_nxt   = last_idx;
        new_grant  = 1'b0;
        pick_any   = rr_pick(req, last_idx);
        // The current owner is masked so a release or preemption never re-grants itself.
        pick_other = rr_pick(req & ~(4'b0001 << gnt_idx), last_idx);

        unique case (state)
            IDLE: begin
                if (pick_any[2]) begin
                    state_nxt = GRANT;
                    idx_nxt   = pick_any[1:0];
                    new_grant = 1'b1;
                end
            end
            GRANT: begin
                if (!req[gnt_idx] || timeout) begin
                    if (pick_other[2]) begin
                        idx_nxt   = pick_other[1:0];
                        new_grant = 1'b1;
                    end else if (!req[gnt_idx]) begin
                        state_nxt = IDLE;
                        idx_nxt   = 2'd0;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (new_grant) last_nxt = idx_nxt;
        gnt_nxt = (state_nxt == GRANT) ? (4'b0001 << idx_nxt) : 4'b0000;
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            state    <= IDLE;
            gnt      <= 4'b0000;
            gnt_idx  <= 2'd0;
            last_idx <= 2'd3;
        end else begin
            state    <= state_nxt;
            gnt      <= gnt_nxt;
            gnt_idx  <= idx_nxt;
            last_idx <= last_nxt;
        end
    end

`ifdef RR_ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_MAX = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] hold_cnt;
    logic       preempt_q;

    assign timeout = (hold_cnt == HOLD_MAX);
    assign preempt = preempt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_cnt  <= 8'd0;
            preempt_q <= 1'b0;
        end else begin
            // A new grant while the owner still requests can only be a timeout handoff.
            preempt_q <= new_grant && (state == GRANT) && req[gnt_idx];
            if (new_grant) begin
                hold_cnt <= 8'd0;
            end else if (state == GRANT && !timeout) begin
                hold_cnt <= hold_cnt + 8'd1;
            end
        end
    end
`else
    assign timeout = 1'b0;
    assign preempt = 1'b0;
`endif

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Self-checking bench for rr_arbiter_4: directed scenarios plus randomized requests
// compared every cycle against an owner/last-index reference model.
module tb_rr_arbiter_4;
    localparam int T = 4;
`ifdef RR_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_valid;
    logic       preempt;

    int errors = 0;
    int checks = 0;

    // Reference model: owner index (-1 when idle), last granted index, hold cycles.
    int m_owner = -1;
    int m_last  = 3;
    int m_hold  = 0;
    bit m_pre   = 1'b0;

    rr_arbiter_4 #(.TIMEOUT_CYCLES(T)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .preempt   (preempt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int rr_search(input logic [3:0] r, input int last, input int excl);
        for (int k = 1; k <= 4; k++) begin
            int c = (last + k) % 4;
            if (c != excl && r[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_step(input logic [3:0] r, input logic rs);
        int w;
        bit rel;
        bit to;
        bit granted;
        m_pre = 1'b0;
        if (!rs) begin
            m_owner = -1;
            m_last  = 3;
            m_hold  = 0;
        end else if (m_owner < 0) begin
            w = rr_search(r, m_last, -1);
            if (w >= 0) begin
                m_owner = w;
                m_last  = w;
                m_hold  = 0;
            end
        end else begin
            rel     = !r[m_owner];
            to      = TO_EN && (m_hold == T - 1);
            granted = 1'b0;
            if (rel || to) begin
                w = rr_search(r, m_last, m_owner);
                if (w >= 0) begin
                    m_pre   = !rel;
                    m_owner = w;
                    m_last  = w;
                    m_hold  = 0;
                    granted = 1'b1;
                end else if (rel) begin
                    m_owner = -1;
                end
            end
            if (!granted && m_hold < T - 1) m_hold++;
        end
    endtask

    task automatic compare_model();
        logic [3:0] eg;
        logic [1:0] ei;
        eg = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
        ei = (m_owner < 0) ? 2'd0 : 2'(m_owner);
        check("model_gnt", 32'(gnt), 32'(eg));
        check("model_gnt_idx", 32'(gnt_idx), 32'(ei));
        check("model_gnt_valid", 32'(gnt_valid), 32'(m_owner >= 0));
        check("model_preempt", 32'(preempt), 32'(m_pre));
    endtask

    // Drive inputs away from the edge, clock once, advance the model, sample 1 time unit later.
    task automatic step(input logic [3:0] r, input logic rs);
        req   = r;
        rst_n = rs;
        @(posedge clk);
        model_step(r, rs);
        #1;
        compare_model();
    endtask

    task automatic expect_out(input string tag, input logic [3:0] g, input logic [1:0] i,
                              input logic v, input logic p);
        check({tag, "_gnt"}, 32'(gnt), 32'(g));
        check({tag, "_idx"}, 32'(gnt_idx), 32'(i));
        check({tag, "_valid"}, 32'(gnt_valid), 32'(v));
        check({tag, "_preempt"}, 32'(preempt), 32'(p));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] rq;
        req   = 4'b0000;
        rst_n = 1'b0;

        step(4'b0000, 1'b0);
        expect_out("reset", 4'b0000, 2'd0, 1'b0, 1'b0);

        // Reset priority, then rotation with zero-bubble handoffs.
        step(4'b1111, 1'b1);
        expect_out("first_grant", 4'b0001, 2'd0, 1'b1, 1'b0);
        step(4'b1111, 1'b1);
        expect_out("hold0", 4'b0001, 2'd0, 1'b1, 1'b0);
        step(4'b1110, 1'b1);
        expect_out("rot1", 4'b0010, 2'd1, 1'b1, 1'b0);
        step(4'b1101, 1'b1);
        expect_out("rot2", 4'b0100, 2'd2, 1'b1, 1'b0);
        step(4'b1011, 1'b1);
        expect_out("rot3", 4'b1000, 2'd3, 1'b1, 1'b0);
        step(4'b0111, 1'b1);
        expect_out("rot0", 4'b0001, 2'd0, 1'b1, 1'b0);

        // Skip and wrap from last_idx=2.
        step(4'b0000, 1'b0);
        step(4'b0100, 1'b1);
        expect_out("own2", 4'b0100, 2'd2, 1'b1, 1'b0);
        step(4'b0011, 1'b1);
        expect_out("wrap", 4'b0001, 2'd0, 1'b1, 1'b0);

        // Release to idle keeps last_idx=1, so next full request goes to 2.
        step(4'b0000, 1'b0);
        step(4'b0010, 1'b1);
        expect_out("own1", 4'b0010, 2'd1, 1'b1, 1'b0);
        step(4'b0000, 1'b1);
        expect_out("idle", 4'b0000, 2'd0, 1'b0, 1'b0);
        step(4'b0000, 1'b1);
        expect_out("idle_stay", 4'b0000, 2'd0, 1'b0, 1'b0);
        step(4'b1111, 1'b1);
        expect_out("after_idle", 4'b0100, 2'd2, 1'b1, 1'b0);

        // Preemption after T grant cycles (only with the timeout feature).
        step(4'b0000, 1'b0);
        step(4'b0001, 1'b1);
        expect_out("pre_own0", 4'b0001, 2'd0, 1'b1, 1'b0);
        for (int i = 0; i < T - 1; i++) begin
            step(4'b0101, 1'b1);
            expect_out("pre_hold", 4'b0001, 2'd0, 1'b1, 1'b0);
        end
        step(4'b0101, 1'b1);
        if (TO_EN) expect_out("pre_move", 4'b0100, 2'd2, 1'b1, 1'b1);
        else       expect_out("pre_move", 4'b0001, 2'd0, 1'b1, 1'b0);
        step(4'b0101, 1'b1);
        if (TO_EN) expect_out("pre_after", 4'b0100, 2'd2, 1'b1, 1'b0);
        else       expect_out("pre_after", 4'b0001, 2'd0, 1'b1, 1'b0);

        // Mid-grant reset.
        step(4'b0000, 1'b0);
        step(4'b1000, 1'b1);
        expect_out("own3", 4'b1000, 2'd3, 1'b1, 1'b0);
        step(4'b1000, 1'b0);
        expect_out("mid_reset", 4'b0000, 2'd0, 1'b0, 1'b0);
        step(4'b1000, 1'b1);
        expect_out("post_reset", 4'b1000, 2'd3, 1'b1, 1'b0);

        // Randomized traffic: each request bit toggles with probability 1/4, rare resets.
        step(4'b0000, 1'b0);
        rq = 4'b0000;
        for (int n = 0; n < 3000; n++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 3) == 0) rq[b] = ~rq[b];
            end
            step(rq, ($urandom_range(0, 99) != 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
